// File: rtl/zombie_pkg.sv
// zombie_pkg: shared definitions for the zombie wave controller.
//   - one-hot game state encoding (also published on the state output)
//   - lane geometry constants (lane count, X width, kill counter width)
//   - pick_free_lane: cyclic free-lane search used by the spawner
package zombie_pkg;

  localparam int NUM_LANES = 5;
  localparam int X_W       = 10;
  localparam int KILL_W    = 16;

  typedef enum logic [7:0] {
    ST_I      = 8'h01,
    ST_L1     = 8'h02,
    ST_NL2    = 8'h04,
    ST_L2     = 8'h08,
    ST_NL3    = 8'h10,
    ST_L3     = 8'h20,
    ST_DONE_L = 8'h40,
    ST_DONE_W = 8'h80
  } state_t;

  // Returns {found, lane}. Starting at cand, scan upward (wrapping) for the
  // first inactive lane. Iterating offsets from high to low lets the lowest
  // offset overwrite the result last, so it wins.
  function automatic logic [3:0] pick_free_lane(input logic [NUM_LANES-1:0] act,
                                                input logic [2:0]           cand);
    logic [3:0] res;
    int         idx;
    res = 4'b0000;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = int'(cand) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!act[idx]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

endpackage

// File: rtl/zombie_lfsr.sv
// zombie_lfsr: 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11) used to pick
// the candidate spawn lane.
//   clk, reset_n : clock, asynchronous active-low reset (loads SEED)
//   en           : advance the register by one step
//   lane         : current register value mod 5 (0..4)
module zombie_lfsr
  import zombie_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [2:0] lane
);

  logic [15:0] lfsr_q;

  // Right-shifting Galois form: feedback taps for bits 16,14,13,11 -> 16'hB400.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign lane = 3'(lfsr_q % 16'd5);

endmodule

// File: rtl/zombie_wave_ctrl.sv
// zombie_wave_ctrl: game logic for the five lane zombies, feeding the VGA
// colouring stage. Handles spawning, leftward movement, kills, the level FSM
// and frame-stable display copies of the zombie state.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : pulse; begin game / next level / restart
//   frame_start    : pulse at start of vertical blanking; latches display copies
//   kill_valid     : hit event; single-cycle, no backpressure (no ready exists,
//                    an event is taken or ignored in the cycle it is valid)
//   kill_lane      : lane of the hit, values >= 5 are ignored
//   zombie_x       : display copy of X positions, lane i at [10i+9:10i]
//   zombie_active  : display copy of active flags
//   state          : one-hot game state (also the FSM debug view)
//   zombies_killed : kills this game, saturating
module zombie_wave_ctrl
  import zombie_pkg::*;
#(
  parameter int          SPEED_DIV    = 500000,
  parameter logic [9:0]  SPAWN_X      = 10'd639,
  parameter logic [9:0]  END_OF_LAWN  = 10'd0,
  parameter int          KILLS_L1     = 5,
  parameter int          KILLS_L2     = 10,
  parameter int          KILLS_L3     = 15,
  parameter int          SPAWN_IVL_L1 = 200,
  parameter int          SPAWN_IVL_L2 = 150,
  parameter int          SPAWN_IVL_L3 = 100,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        frame_start,
  input  logic        kill_valid,
  input  logic [2:0]  kill_lane,
  output logic [49:0] zombie_x,
  output logic [4:0]  zombie_active,
  output logic [7:0]  state,
  output logic [15:0] zombies_killed
);

  localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int CNT_W = 16;

  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  state_t               state_q, state_d;
  logic [X_W-1:0]       wx_q [NUM_LANES];
  logic [X_W-1:0]       wx_d [NUM_LANES];
  logic [NUM_LANES-1:0] wact_q, wact_d;
  logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d, spawn_cnt_inc;
  logic [CNT_W-1:0]     level_kills_q, level_kills_d;
  logic [CNT_W-1:0]     ivl, kill_goal;
  logic [KILL_W-1:0]    killed_q, killed_d;
  logic                 in_l, loss, kill_ok, lfsr_en;
  logic [2:0]           cand_lane;
  logic [3:0]           free_pick;
  logic [7:0]           act_pad;

  // Move tick divider, free-running in every state.
  assign tick = (div_q == DIV_W'(SPEED_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= tick ? '0 : div_q + 1'b1;
  end

  assign in_l    = (state_q == ST_L1) || (state_q == ST_L2) || (state_q == ST_L3);
  assign lfsr_en = tick && in_l;
  // Padding lets an out-of-range kill_lane index a defined zero.
  assign act_pad = {3'b000, wact_q};

  zombie_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (lfsr_en),
    .lane    (cand_lane)
  );

  // Per-level spawn interval and kill target.
  always_comb begin
    ivl       = CNT_W'(SPAWN_IVL_L1);
    kill_goal = CNT_W'(KILLS_L1);
    case (state_q)
      ST_L2: begin
        ivl       = CNT_W'(SPAWN_IVL_L2);
        kill_goal = CNT_W'(KILLS_L2);
      end
      ST_L3: begin
        ivl       = CNT_W'(SPAWN_IVL_L3);
        kill_goal = CNT_W'(KILLS_L3);
      end
      default: ;
    endcase
  end

  // Work-register update (kill, then move, then spawn) and FSM next state.
  always_comb begin
    wx_d          = wx_q;
    wact_d        = wact_q;
    spawn_cnt_d   = spawn_cnt_q;
    spawn_cnt_inc = spawn_cnt_q + 1'b1;
    level_kills_d = level_kills_q;
    killed_d      = killed_q;
    loss          = 1'b0;
    free_pick     = 4'b0000;
    state_d       = state_q;
    kill_ok       = in_l && kill_valid && (kill_lane < 3'd5) && act_pad[kill_lane];

    if (kill_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (kill_lane == 3'(i)) wact_d[i] = 1'b0;
      end
      if (killed_q != {KILL_W{1'b1}}) killed_d = killed_q + 1'b1;
      level_kills_d = level_kills_q + 1'b1;
    end

    if (in_l && tick) begin
      // Movement looks at post-kill flags, so a lane killed this cycle
      // neither moves nor causes a loss.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wact_d[i]) begin
          if (wx_q[i] == END_OF_LAWN + X_W'(1)) loss = 1'b1;
          wx_d[i] = wx_q[i] - X_W'(1);
        end
      end
      if (spawn_cnt_inc == ivl) begin
        spawn_cnt_d = '0;
        free_pick   = pick_free_lane(wact_d, cand_lane);
        // The chosen lane was inactive, so it was not moved above.
        if (free_pick[3]) begin
          wact_d[free_pick[2:0]] = 1'b1;
          wx_d[free_pick[2:0]]   = SPAWN_X;
        end
      end else begin
        spawn_cnt_d = spawn_cnt_inc;
      end
    end

    case (state_q)
      ST_I:      if (start) state_d = ST_L1;
      ST_L1:     if (loss) state_d = ST_DONE_L;
                 else if (level_kills_q == kill_goal) state_d = ST_NL2;
      ST_NL2:    if (start) state_d = ST_L2;
      ST_L2:     if (loss) state_d = ST_DONE_L;
                 else if (level_kills_q == kill_goal) state_d = ST_NL3;
      ST_NL3:    if (start) state_d = ST_L3;
      ST_L3:     if (loss) state_d = ST_DONE_L;
                 else if (level_kills_q == kill_goal) state_d = ST_DONE_W;
      ST_DONE_L,
      ST_DONE_W: if (start) state_d = ST_I;
      default:   state_d = ST_I;
    endcase

    // Leaving a level wipes the lawn for the next one.
    if (in_l && (state_d != state_q)) begin
      wact_d        = '0;
      level_kills_d = '0;
      spawn_cnt_d   = '0;
      for (int i = 0; i < NUM_LANES; i++) wx_d[i] = SPAWN_X;
    end

    if ((state_d == ST_I) && (state_q != ST_I)) killed_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_I;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wact_q        <= '0;
      spawn_cnt_q   <= '0;
      level_kills_q <= '0;
      killed_q      <= '0;
      zombie_active <= '0;
      zombie_x      <= {NUM_LANES{SPAWN_X}};
      for (int i = 0; i < NUM_LANES; i++) wx_q[i] <= SPAWN_X;
    end else begin
      wact_q        <= wact_d;
      spawn_cnt_q   <= spawn_cnt_d;
      level_kills_q <= level_kills_d;
      killed_q      <= killed_d;
      for (int i = 0; i < NUM_LANES; i++) wx_q[i] <= wx_d[i];
      // Display copies change only once per frame so the renderer sees a
      // consistent picture.
      if (frame_start) begin
        zombie_active <= wact_q;
        for (int i = 0; i < NUM_LANES; i++) zombie_x[i*X_W +: X_W] <= wx_q[i];
      end
    end
  end

  assign state          = state_q;
  assign zombies_killed = killed_q;

endmodule
